// File: rtl/reg_writeback_queue_pkg.sv
// Shared types and constants for the register write-back queue.
package reg_writeback_queue_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int WBQ_DEPTH  = 4;

    typedef logic [DATA_WIDTH-1:0] wbq_word_t;

    function automatic bit is_pow2(input int n);
        return (n >= 2) && ((n & (n - 1)) == 0);
    endfunction

endpackage

// File: rtl/reg_wbq_storage.sv
// Entry array for the write-back queue: one synchronous write port, one async read port.
module reg_wbq_storage
    import reg_writeback_queue_pkg::*;
#(
    parameter  int DATA_WIDTH = reg_writeback_queue_pkg::DATA_WIDTH,
    parameter  int DEPTH      = WBQ_DEPTH,
    localparam int PTR_W      = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_W-1:0]      waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [PTR_W-1:0]      raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    // No reset: stale contents are unreachable once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/reg_writeback_queue.sv
// Write-back FIFO feeding Common_Register as an oen/odata pulse train.
// Optional WBQ_BYPASS_EN: an empty, unstalled queue forwards a push straight to odata.
module reg_writeback_queue
    import reg_writeback_queue_pkg::*;
#(
    parameter  int DATA_WIDTH = reg_writeback_queue_pkg::DATA_WIDTH,
    parameter  int DEPTH      = WBQ_DEPTH,
    localparam int CNT_W      = $clog2(DEPTH) + 1
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  ivalid,
    input  logic [DATA_WIDTH-1:0] idata,
    output logic                  oready,
    input  logic                  istall,
    output logic                  oen,
    output logic [DATA_WIDTH-1:0] odata,
    output logic [CNT_W-1:0]      ocount,
    output logic                  ofull,
    output logic                  oempty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  push;
    logic                  pop;
    logic                  bypass;
    logic                  store;

    // Handshake: a word transfers on a rising edge where ivalid & oready are both high;
    // oready never depends on ivalid, and a full queue refuses even if it drains that edge.
    assign oempty = (ocount == '0);
    assign ofull  = (ocount == CNT_W'(DEPTH));
    assign oready = !ofull && !irst;
    assign push   = ivalid && oready;
    assign pop    = !oempty && !istall;

`ifdef WBQ_BYPASS_EN
    assign bypass = oempty && !istall && push;
`else
    assign bypass = 1'b0;
`endif

    assign store = push && !bypass;

    reg_wbq_storage #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_storage (
        .clk   (iclk),
        .we    (store),
        .waddr (wr_ptr),
        .wdata (idata),
        .raddr (rd_ptr),
        .rdata (rd_data)
    );

    always_ff @(posedge iclk) begin
        if (irst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            ocount <= '0;
            oen    <= 1'b0;
            odata  <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            // Bypass only fires when empty, so it can never collide with a pop.
            if (pop) begin
                odata <= rd_data;
            end else if (bypass) begin
                odata <= idata;
            end
            oen <= pop || bypass;
            case ({store, pop})
                2'b10:   ocount <= ocount + CNT_W'(1);
                2'b01:   ocount <= ocount - CNT_W'(1);
                default: ocount <= ocount;
            endcase
        end
    end

    a_depth_pow2: assert property (@(posedge iclk) is_pow2(DEPTH));
    a_no_push_full: assert property (@(posedge iclk) disable iff (irst) !(store && ofull));
    a_no_pop_empty: assert property (@(posedge iclk) disable iff (irst) !(pop && oempty));

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: scoreboard on the oen/odata stream plus
// directed checks on occupancy, flags and reset.
module tb_reg_writeback_queue;

    localparam int W     = 16;
    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH) + 1;
`ifdef WBQ_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif

    logic             iclk = 1'b0;
    logic             irst = 1'b1;
    logic             ivalid = 1'b0;
    logic [W-1:0]     idata = '0;
    logic             oready;
    logic             istall = 1'b0;
    logic             oen;
    logic [W-1:0]     odata;
    logic [CNT_W-1:0] ocount;
    logic             ofull;
    logic             oempty;

    logic [W-1:0] exp_q[$];
    int           errors = 0;
    int           checks = 0;
    int           oen_seen = 0;

    // clock / reset
    always #5 iclk = ~iclk;

    reg_writeback_queue dut (
        .iclk   (iclk),
        .irst   (irst),
        .ivalid (ivalid),
        .idata  (idata),
        .oready (oready),
        .istall (istall),
        .oen    (oen),
        .odata  (odata),
        .ocount (ocount),
        .ofull  (ofull),
        .oempty (oempty)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // driver tasks: inputs change on the falling edge, outputs sampled there too
    task automatic tick();
        @(negedge iclk);
    endtask

    task automatic push_word(input logic [W-1:0] d, input bit accept);
        ivalid = 1'b1;
        idata  = d;
        if (accept) exp_q.push_back(d);
        tick();
        ivalid = 1'b0;
    endtask

    // scoreboard: every load strobe must match the oldest outstanding expected word
    always @(negedge iclk) begin
        if (oen === 1'b1) begin
            oen_seen++;
            if (exp_q.size() == 0) check("sb_unexpected_oen", 32'd1, 32'd0);
            else check("sb_odata", 32'(odata), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int base;
        int first;
        int last;
        int n;

        // 1: reset with ivalid asserted
        irst   = 1'b1;
        ivalid = 1'b1;
        idata  = 16'h00FF;
        tick();
        tick();
        check("rst_oen", 32'(oen), 32'd0);
        check("rst_odata", 32'(odata), 32'd0);
        check("rst_ocount", 32'(ocount), 32'd0);
        check("rst_oready", 32'(oready), 32'd0);
        check("rst_oempty", 32'(oempty), 32'd1);
        check("rst_ofull", 32'(ofull), 32'd0);
        ivalid = 1'b0;
        irst   = 1'b0;
        tick();
        check("post_rst_oready", 32'(oready), 32'd1);

        // 2: single word latency
        ivalid = 1'b1;
        idata  = 16'h000A;
        exp_q.push_back(16'h000A);
        tick();
        ivalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            check($sformatf("single_oen_c%0d", c), 32'(oen), (c == LAT) ? 32'd1 : 32'd0);
            if (c == LAT) check("single_odata", 32'(odata), 32'h000A);
            if (c < 3) tick();
        end
        check("single_oempty", 32'(oempty), 32'd1);

        // 3: fill while stalled, overflow ignored, drain in order
        istall = 1'b1;
        push_word(16'd10, 1'b1);
        push_word(16'd5, 1'b1);
        push_word(16'd12, 1'b1);
        push_word(16'd2, 1'b1);
        check("fill_ofull", 32'(ofull), 32'd1);
        check("fill_oready", 32'(oready), 32'd0);
        check("fill_ocount", 32'(ocount), 32'd4);
        push_word(16'd7, 1'b0);
        check("overflow_ocount", 32'(ocount), 32'd4);
        istall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("drain_oen_%0d", k), 32'(oen), 32'd1);
            check($sformatf("drain_ocount_%0d", k), 32'(ocount), 32'(3 - k));
        end
        tick();
        check("drain_done_oen", 32'(oen), 32'd0);

        // 4: back-to-back stream
        first = -1;
        last  = -1;
        n     = 0;
        for (int i = 0; i < 12; i++) begin
            ivalid = (i < 8);
            idata  = W'(i + 1);
            if (i < 8) exp_q.push_back(W'(i + 1));
            tick();
            if (oen === 1'b1) begin
                if (first < 0) first = i;
                last = i;
                n++;
            end
            if (ocount > 1) check($sformatf("stream_ocount_%0d", i), 32'(ocount), 32'd1);
        end
        ivalid = 1'b0;
        check("stream_pulses", 32'(n), 32'd8);
        check("stream_gapless", 32'(last - first + 1), 32'd8);

        // 5: stall after first pop
        istall = 1'b1;
        push_word(16'd20, 1'b1);
        push_word(16'd21, 1'b1);
        push_word(16'd22, 1'b1);
        istall = 1'b0;
        tick();
        check("stall_first_oen", 32'(oen), 32'd1);
        check("stall_first_ocount", 32'(ocount), 32'd2);
        istall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            tick();
            check($sformatf("stall_hold_oen_%0d", k), 32'(oen), 32'd0);
            check($sformatf("stall_hold_odata_%0d", k), 32'(odata), 32'd20);
            check($sformatf("stall_hold_ocount_%0d", k), 32'(ocount), 32'd2);
        end
        istall = 1'b0;
        tick();
        check("resume_ocount_1", 32'(ocount), 32'd1);
        tick();
        check("resume_ocount_0", 32'(ocount), 32'd0);
        tick();
        check("resume_done_oen", 32'(oen), 32'd0);

        // 6: reset mid-burst discards queued data
        istall = 1'b1;
        push_word(16'd30, 1'b0);
        push_word(16'd31, 1'b0);
        push_word(16'd32, 1'b0);
        irst = 1'b1;
        tick();
        check("midrst_ocount", 32'(ocount), 32'd0);
        check("midrst_oen", 32'(oen), 32'd0);
        check("midrst_oempty", 32'(oempty), 32'd1);
        check("midrst_oready", 32'(oready), 32'd0);
        irst   = 1'b0;
        istall = 1'b0;
        base   = oen_seen;
        push_word(16'h0003, 1'b1);
        tick();
        tick();
        tick();
        check("midrst_single_pulse", 32'(oen_seen - base), 32'd1);
        check("midrst_final_oempty", 32'(oempty), 32'd1);

        check("sb_queue_drained", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
